// File: rtl/sig_capture_pkg.sv
// sig_capture_pkg -- shared types and default widths for the triggered
// sample recorder.
//
// Contents:
//   DEFAULT_ADDRESS_WIDTH  default buffer address width (depth = 2**width)
//   DEFAULT_DATA_WIDTH     default sample width
//   DECIM_WIDTH            width of the decimation control
//   capture_state_t        recorder state: IDLE, ARMED, CAPTURE, DONE
package sig_capture_pkg;

  localparam int DEFAULT_ADDRESS_WIDTH = 8;
  localparam int DEFAULT_DATA_WIDTH    = 8;
  localparam int DECIM_WIDTH           = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } capture_state_t;

endpackage

// File: rtl/sig_capture_if.sv
// sig_capture_if -- control, sample and readout signals of the recorder.
//
// Signals:
//   arm        single-cycle arm request
//   trigger    trigger level, capture starts on its rising edge
//   din_valid  din carries a sample this cycle
//   din        input sample
//   decim      store every (decim+1)-th valid sample
//   rd_addr    readout address
//   rd_data    readout data, one cycle after rd_addr
//   busy       recorder is armed or capturing
//   done       a full buffer has been captured
//   count      samples written in the current capture
//
// Modports:
//   master  drives controls/samples, observes status (source / controller)
//   slave   the recorder itself
interface sig_capture_if
  import sig_capture_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
);

  logic                     arm;
  logic                     trigger;
  logic                     din_valid;
  logic [DATA_WIDTH-1:0]    din;
  logic [DECIM_WIDTH-1:0]   decim;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     busy;
  logic                     done;
  logic [ADDRESS_WIDTH:0]   count;

  modport master (
    output arm, trigger, din_valid, din, decim, rd_addr,
    input  rd_data, busy, done, count
  );

  modport slave (
    input  arm, trigger, din_valid, din, decim, rd_addr,
    output rd_data, busy, done, count
  );

endinterface

// File: rtl/sig_capture_ram.sv
// capture_ram -- simple dual-port sample buffer for the recorder.
//
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset (read register only)
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  registered read data, one cycle after raddr
//
// A read and a write to the same address in one cycle return the previous
// contents: the read register samples the array before the write lands.
module capture_ram
  import sig_capture_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; captured data
  // also has to survive a controller reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // NOTE: non-blocking assignment here is what gives read-before-write:
  // rdata takes the array value from before this edge's write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sig_capture.sv
// sig_capture -- triggered sample recorder.
//
// Arms on request, waits for a rising edge on trigger, then writes one full
// buffer of decimated input samples into capture_ram. The buffer can be read
// back at any time through a registered read port.
//
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  sig_capture_if.slave: arm, trigger, din_valid, din, decim, rd_addr
//        in; rd_data, busy, done, count out
//
// All outputs come from registers or are decoded from the state register.
module sig_capture
  import sig_capture_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  sig_capture_if.slave  bus
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = '1;

  capture_state_t           state;
  capture_state_t           state_next;
  logic                     trig_q;
  logic                     trig_edge;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [ADDRESS_WIDTH:0]   count;
  logic [DECIM_WIDTH-1:0]   dec_cnt;
  logic                     arm_accept;
  logic                     sample_seen;
  logic                     wr_en;
  logic                     last_write;

  // trig_q follows trigger in every state, so a trigger already high when
  // arm arrives produces no edge until it has dropped and risen again.
  assign trig_edge   = bus.trigger & ~trig_q;

  // Arm is honoured only when no capture is in progress.
  assign arm_accept  = bus.arm && (state == IDLE || state == DONE);
  assign sample_seen = (state == CAPTURE) && bus.din_valid;
  assign wr_en       = sample_seen && (dec_cnt == '0);
  assign last_write  = wr_en && (wr_ptr == LAST_ADDR);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  // NOTE: state_next gets its default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.arm)    state_next = ARMED;
      ARMED:   if (trig_edge)  state_next = CAPTURE;
      CAPTURE: if (last_write) state_next = DONE;
      DONE:    if (bus.arm)    state_next = ARMED;
      default:                 state_next = IDLE;
    endcase
  end

  // Trigger history, write pointer, sample count and decimation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q  <= 1'b0;
      wr_ptr  <= '0;
      count   <= '0;
      dec_cnt <= '0;
    end else begin
      trig_q <= bus.trigger;

      if (arm_accept) begin
        wr_ptr <= '0;
        count  <= '0;
      end

      // The first valid sample after the edge is always stored.
      if (state == ARMED && trig_edge) begin
        dec_cnt <= '0;
      end

      // decim is only looked at on reload, so a mid-capture change takes
      // effect from the next stored sample onwards. wr_ptr wraps to 0 after
      // the final write and stays unused until the next arm.
      if (sample_seen) begin
        if (dec_cnt == '0) begin
          wr_ptr  <= wr_ptr + 1'b1;
          count   <= count + 1'b1;
          dec_cnt <= bus.decim;
        end else begin
          dec_cnt <= dec_cnt - 1'b1;
        end
      end
    end
  end

  capture_ram #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (bus.din),
    .raddr (bus.rd_addr),
    .rdata (bus.rd_data)
  );

  assign bus.busy  = (state == ARMED) || (state == CAPTURE);
  assign bus.done  = (state == DONE);
  assign bus.count = count;

endmodule

// File: tb/tb_sig_capture.sv
// tb_sig_capture -- self-checking bench for sig_capture.
//
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at the same point, i.e. well away from the next active edge.
module tb_sig_capture;
  import sig_capture_pkg::*;

  localparam int AW    = DEFAULT_ADDRESS_WIDTH;
  localparam int DW    = DEFAULT_DATA_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sig_capture_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sig_capture #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    string       name;
    logic        arm;
    logic        trigger;
    logic        din_valid;
    logic [7:0]  din;
    logic        exp_busy;
    logic        exp_done;
    int          exp_count;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.arm       = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
  endtask

  // Arm, then produce a clean low-to-high trigger; the recorder is in
  // CAPTURE once this returns.
  task automatic arm_and_trigger(input string name);
    idle_inputs();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    check({name, "_arm_busy"}, 32'(bus.busy), 32'd1);
    check({name, "_arm_done"}, 32'(bus.done), 32'd0);
    check({name, "_arm_count"}, 32'(bus.count), 32'd0);
    bus.trigger = 1'b0;
    tick();
    bus.trigger = 1'b1;
    tick();
  endtask

  task automatic readback(input string name);
    idle_inputs();
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_addr = AW'(a);
      tick();
      check($sformatf("%s[%0d]", name, a), 32'(bus.rd_data), 32'(exp_mem[a]));
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.arm       = 1'b0;
    bus.trigger   = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.decim     = '0;
    bus.rd_addr   = '0;

    // ---- reset ----
    tick();
    tick();
    rst = 1'b0;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);

    // ---- control table: trigger without arm, held trigger, edge cycle,
    //      arm/trigger ignored while capturing ----
    vq.push_back('{"idle_trig_edge",   1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 0});
    vq.push_back('{"idle_trig_low",    1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 0});
    vq.push_back('{"idle_trig_valid",  1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 0});
    vq.push_back('{"arm_trig_held",    1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0});
    vq.push_back('{"armed_held_valid", 1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0, 0});
    vq.push_back('{"armed_trig_low",   1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0});
    vq.push_back('{"edge_no_write",    1'b0, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 0});
    vq.push_back('{"first_write",      1'b0, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1});
    vq.push_back('{"invalid_hold",     1'b0, 1'b1, 1'b0, 8'hEE, 1'b1, 1'b0, 1});
    vq.push_back('{"arm_in_capture",   1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 2});
    vq.push_back('{"trig_low_capture", 1'b0, 1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 3});
    vq.push_back('{"edge_in_capture",  1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 4});
    foreach (vq[i]) begin
      bus.arm       = vq[i].arm;
      bus.trigger   = vq[i].trigger;
      bus.din_valid = vq[i].din_valid;
      bus.din       = vq[i].din;
      tick();
      check({vq[i].name, "_busy"},  32'(bus.busy),  32'(vq[i].exp_busy));
      check({vq[i].name, "_done"},  32'(bus.done),  32'(vq[i].exp_done));
      check({vq[i].name, "_count"}, 32'(bus.count), 32'(vq[i].exp_count));
    end
    // Read port works mid-capture.
    idle_inputs();
    begin
      logic [7:0] tbl_exp [4];
      tbl_exp = '{8'h22, 8'h33, 8'h44, 8'h55};
      for (int a = 0; a < 4; a++) begin
        bus.rd_addr = AW'(a);
        tick();
        check($sformatf("table_read[%0d]", a), 32'(bus.rd_data), 32'(tbl_exp[a]));
      end
    end
    rst = 1'b1;
    bus.trigger = 1'b0;
    tick();
    rst = 1'b0;
    check("table_rst_busy", 32'(bus.busy), 32'd0);

    // ---- basic capture, decim = 0 ----
    bus.decim = 8'd0;
    arm_and_trigger("basic");
    for (int i = 0; i < DEPTH; i++) begin
      bus.din_valid = 1'b1;
      bus.din       = 8'(i);
      tick();
      check("basic_count", 32'(bus.count), 32'(i + 1));
      check("basic_done", 32'(bus.done), 32'(i == DEPTH - 1));
      check("basic_busy", 32'(bus.busy), 32'(i != DEPTH - 1));
    end
    for (int a = 0; a < DEPTH; a++) exp_mem[a] = 8'(a);
    readback("basic_mem");
    // Read latency: no combinational path, data one cycle after address.
    bus.rd_addr = 8'd10;
    #2;
    check("latency_before_edge", 32'(bus.rd_data), 32'd255);
    tick();
    check("latency_after_edge", 32'(bus.rd_data), 32'd10);
    check("basic_done_held", 32'(bus.done), 32'd1);
    check("basic_count_held", 32'(bus.count), 32'd256);

    // ---- decimation, decim = 2 ----
    bus.decim = 8'd2;
    arm_and_trigger("decim");
    begin
      int  v    = 0;
      bit  seen = 1'b0;
      for (int c = 0; c < 2000 && !seen; c++) begin
        bus.din_valid = 1'b1;
        bus.din       = v[7:0];
        tick();
        v++;
        if (bus.done) seen = 1'b1;
      end
      check("decim_done_seen", 32'(seen), 32'd1);
      check("decim_valid_cycles", 32'(v), 32'd766);
      check("decim_count", 32'(bus.count), 32'd256);
    end
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = 8'((3 * k) % 256);
    readback("decim_mem");

    // ---- gapped valid, decim = 0 ----
    bus.decim = 8'd0;
    arm_and_trigger("gap");
    for (int i = 0; i < 2 * DEPTH; i++) begin
      bus.din_valid = (i % 2 == 0);
      bus.din       = 8'(i / 2) ^ 8'h5A;
      tick();
      check("gap_count", 32'(bus.count), 32'(i / 2 + 1));
    end
    check("gap_done", 32'(bus.done), 32'd1);
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = 8'(k) ^ 8'h5A;
    readback("gap_mem");

    // ---- trigger high before arm, then reset mid-capture ----
    idle_inputs();
    bus.trigger = 1'b1;
    tick();
    tick();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.din_valid = 1'b1;
      tick();
      check("held_trig_busy", 32'(bus.busy), 32'd1);
      check("held_trig_count", 32'(bus.count), 32'd0);
    end
    bus.din_valid = 1'b0;
    bus.trigger   = 1'b0;
    tick();
    bus.trigger = 1'b1;
    tick();
    bus.din_valid = 1'b1;
    bus.din       = 8'h3C;
    tick();
    check("held_trig_first_write", 32'(bus.count), 32'd1);
    for (int i = 1; i < 100; i++) tick();
    check("mid_count", 32'(bus.count), 32'd100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
    arm_and_trigger("rearm");
    for (int i = 0; i < DEPTH; i++) begin
      bus.din_valid = 1'b1;
      bus.din       = 8'hA5;
      tick();
    end
    check("rearm_done", 32'(bus.done), 32'd1);
    check("rearm_count", 32'(bus.count), 32'd256);
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = 8'hA5;
    readback("rearm_mem");

    // ---- randomized captures against a reference model ----
    // Valid sample number n (from 0) is stored iff n is a multiple of
    // decim+1, at address n/(decim+1); the count is the number stored.
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 8'hA5;
    for (int r = 0; r < 4; r++) begin
      int d         = int'($urandom_range(0, 3));
      int n_valid   = 0;
      int exp_count = 0;
      bus.decim = 8'(d);
      arm_and_trigger("rand");
      for (int c = 0; c < 3000 && exp_count < DEPTH; c++) begin
        logic          v;
        logic [DW-1:0] dv;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp_rd;
        v  = ($urandom_range(0, 3) != 0);
        dv = 8'($urandom);
        ra = ($urandom_range(0, 3) == 0) ? AW'(exp_count) : AW'($urandom);
        exp_rd = ref_mem[ra];
        bus.din_valid = v;
        bus.din       = dv;
        bus.rd_addr   = ra;
        tick();
        if (v) begin
          if (n_valid % (d + 1) == 0) ref_mem[n_valid / (d + 1)] = dv;
          n_valid++;
        end
        exp_count = (n_valid + d) / (d + 1);
        check("rand_count", 32'(bus.count), 32'(exp_count));
        check("rand_rd_data", 32'(bus.rd_data), 32'(exp_rd));
        check("rand_done", 32'(bus.done), 32'(exp_count == DEPTH));
        check("rand_busy", 32'(bus.busy), 32'(exp_count != DEPTH));
      end
      check("rand_finished", 32'(exp_count), 32'(DEPTH));
    end
    for (int k = 0; k < DEPTH; k++) exp_mem[k] = ref_mem[k];
    readback("rand_mem");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sig_capture.md
# sig_capture

Triggered sample recorder: the write-side counterpart of the waveform ROM. Arms on request, waits for a rising edge on a trigger input, then writes a full buffer of decimated input samples into an internal dual-port RAM. A registered read port lets playback or display logic read the captured buffer the same way it reads the sine table. It sits between the signal source (ADC or generator output) and the playback/readout path.

## Interface
- ADDRESS_WIDTH, default 8: buffer depth is 2**ADDRESS_WIDTH samples.
- DATA_WIDTH, default 8: sample width.

Ports:
- clk  input  1  system clock; all logic on posedge clk.
- rst  input  1  reset, synchronous, active-high.
- arm  input  1  single-cycle arm request.
- trigger  input  1  trigger level; capture starts on its rising edge.
- din_valid  input  1  din carries a sample this cycle.
- din  input  DATA_WIDTH  input sample.
- decim  input  8  decimation: store every (decim+1)-th valid sample; 0 stores all.
- rd_addr  input  ADDRESS_WIDTH  readout address.
- rd_data  output  DATA_WIDTH  readout data, registered.
- busy  output  1  high in ARMED or CAPTURE.
- done  output  1  high in DONE.
- count  output  ADDRESS_WIDTH+1  samples written in the current capture, 0 to 2**ADDRESS_WIDTH.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE: arm -> ARMED; count and wr_ptr cleared to 0.
- ARMED: trig_q registers trigger every cycle in all states; edge = trigger & ~trig_q. On edge -> CAPTURE, dec_cnt cleared to 0. No write on the edge cycle.
- CAPTURE, each cycle with din_valid=1:
  - dec_cnt==0: write din to RAM[wr_ptr], wr_ptr+1, count+1, dec_cnt loads decim.
  - otherwise dec_cnt decrements and nothing is written.
  - Cycles with din_valid=0 change nothing.
- The write to address 2**ADDRESS_WIDTH-1 ends the capture: -> DONE the next cycle with count=2**ADDRESS_WIDTH. wr_ptr wraps to 0 and is not used again before re-arm.
- DONE: done=1 is held. arm -> ARMED, clearing count, wr_ptr and done. The RAM keeps its contents until overwritten.
- arm in ARMED or CAPTURE is ignored; there is no restart mid-capture.
- decim is sampled only when dec_cnt reloads. Changing decim mid-capture takes effect at the next reload.
- Read port works in every state. rd_data <= RAM[rd_addr] each cycle.
- Read and write to the same address in the same cycle: rd_data returns the old contents (read-before-write).
- rst in any state: IDLE, count=0, wr_ptr=0, dec_cnt=0, trig_q=0, rd_data=0. RAM contents are not cleared.

## Timing
- Reset values: rd_data=0, busy=0, done=0, count=0.
- arm in cycle N: busy=1 from N+1.
- Trigger edge in cycle N (trigger=1, trig_q=0): state=CAPTURE from N+1. The first write is possible in N+1.
- Write in cycle N: count increments in N+1. The data is readable by rd_addr presented in N+1, with rd_data valid in N+2.
- Read latency is 1 cycle: rd_addr in N, rd_data in N+1.
- Final write in cycle N: done=1 and busy=0 in N+1.
- Trigger held high across arm: the capture does not start until trigger goes low and then high again.
- All outputs are registered or decoded directly from registered state; there are no combinational input-to-output paths.

## Structure
- Package sig_capture_pkg holds:
  - typedef enum capture_state_t {IDLE, ARMED, CAPTURE, DONE};
  - the default width constants.
- Sub-module capture_ram holds the 2**ADDRESS_WIDTH x DATA_WIDTH array with one write port (we, waddr, wdata) and one registered read port (raddr, rdata). It has no initial load and no reset on the array.
- The top level holds the FSM, trigger edge detector, decimation counter, wr_ptr and count.

## Test plan
- Reset and idle: rst for 2 cycles -> busy=0, done=0, count=0, rd_data=0. Trigger edges without arm cause no writes (count stays 0).
- Basic capture, decim=0: arm, trigger rise, din_valid=1 with din=address counter (0,1,2,...) -> done exactly 256 valid cycles after CAPTURE entry, count=256. Reading addresses 0..255 returns 0..255 with 1-cycle latency.
- Decimation, decim=2: continuous din_valid, din=0,1,2,... -> RAM[k]=3k mod 256. Capture ends after 766 valid cycles.
- Gapped valid, decim=0: din_valid alternating 1/0 -> only valid samples are stored, contiguous in RAM, and count advances every other cycle.
- Trigger high before arm: trigger=1, then arm -> stays ARMED with count=0. Trigger goes 0 then 1 -> capture starts the next cycle.
- Reset mid-capture at count=100 -> next cycle IDLE, count=0, busy=0. Re-arm and capture new data 0xA5 -> RAM[0..255] all 0xA5 and done=1.
